// File: rtl/conv_channel_accum_if.sv
// Stream bundle between the adder tree, the channel accumulator and the consumer.
// Optional feature macro used by the attached block: CONV_ACCUM_RELU_EN.
// Signals:
//   in_valid/in_ready/in_data/bias : per-channel window sum input (bias on first beat)
//   out_valid/out_ready            : finished pixel handshake
//   out_data/out_sat               : signed output pixel and clamp flag
// master = producer/consumer side, slave = accumulator side.
interface conv_channel_accum_if #(
  parameter int unsigned OUT_W = 16
);
  localparam int unsigned IN_W   = 32;
  localparam int unsigned BIAS_W = 16;

  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic [BIAS_W-1:0] bias;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_sat;

  modport master (
    output in_valid, in_data, bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/conv_channel_accum.sv
// Channel accumulator and output stage for the convolution datapath.
// Sums NUM_CH signed window sums plus bias into one pixel, then applies
// optional ReLU, an arithmetic right shift by SHIFT and saturation to OUT_W.
// Optional feature: define CONV_ACCUM_RELU_EN to enable ReLU (MIN clamp = 0).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : conv_channel_accum_if.slave (input stream in, pixel stream out)
module conv_channel_accum #(
  parameter int unsigned NUM_CH = 64,
  parameter int unsigned SHIFT  = 8,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_channel_accum_if.slave  bus
);

  localparam int unsigned ACC_W = 48;
  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CH - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed((ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1));
`ifdef CONV_ACCUM_RELU_EN
  localparam logic signed [ACC_W-1:0] SAT_MIN = '0;
`else
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    $signed(-(ACC_W'(1) << (OUT_W - 1)));
`endif

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        ch_cnt_q, ch_cnt_d;
  logic signed [ACC_W-1:0] fin_q, fin_d;
  logic                    fin_valid_q, fin_valid_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic                    accept;
  logic                    post_fire;

  logic signed [ACC_W-1:0] post_relu;
  logic signed [ACC_W-1:0] post_shift;
  logic signed [ACC_W-1:0] post_clamp;
  logic                    post_sat;

  // Post stage: ReLU, floor shift, clamp of the pending finished sum.
  always_comb begin
    post_relu  = fin_q;
`ifdef CONV_ACCUM_RELU_EN
    if (fin_q[ACC_W-1]) begin
      post_relu = '0;
    end
`endif
    post_shift = post_relu >>> SHIFT;
    post_clamp = post_shift;
    post_sat   = 1'b0;
    if (post_shift > SAT_MAX) begin
      post_clamp = SAT_MAX;
      post_sat   = 1'b1;
    end else if (post_shift < SAT_MIN) begin
      post_clamp = SAT_MIN;
      post_sat   = 1'b1;
    end
  end

  // Next-state logic for accumulation, finish register and output register.
  always_comb begin
    in_ext      = ACC_W'($signed(bus.in_data));
    bias_ext    = ACC_W'($signed(bus.bias));
    // in_ready_q is low exactly while fin holds a pixel, so accept and
    // post_fire never both touch fin_valid in the same cycle.
    accept      = bus.in_valid && in_ready_q;
    post_fire   = fin_valid_q && (!out_valid_q || bus.out_ready);

    acc_d       = acc_q;
    ch_cnt_d    = ch_cnt_q;
    fin_d       = fin_q;
    fin_valid_d = fin_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    if (accept) begin
      if (ch_cnt_q == LAST_CNT) begin
        // Single-channel pixels take bias and data together.
        fin_d       = ((ch_cnt_q == '0) ? bias_ext : acc_q) + in_ext;
        fin_valid_d = 1'b1;
        ch_cnt_d    = '0;
      end else begin
        acc_d    = (ch_cnt_q == '0) ? (in_ext + bias_ext) : (acc_q + in_ext);
        ch_cnt_d = ch_cnt_q + CNT_W'(1);
      end
    end

    if (post_fire) begin
      out_data_d  = OUT_W'(post_clamp);
      out_sat_d   = post_sat;
      out_valid_d = 1'b1;
      fin_valid_d = 1'b0;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = !fin_valid_d;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      ch_cnt_q    <= '0;
      fin_q       <= '0;
      fin_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ch_cnt_q    <= ch_cnt_d;
      fin_q       <= fin_d;
      fin_valid_q <= fin_valid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_conv_channel_accum.sv
// Self-checking bench for conv_channel_accum: two instances (NUM_CH=4/SHIFT=8
// and NUM_CH=1/SHIFT=0), directed scenarios plus a randomized stream checked
// against an arithmetic reference model.
module tb_conv_channel_accum;

  localparam int unsigned OUT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_channel_accum_if #(.OUT_W(OUT_W)) a_if ();
  conv_channel_accum_if #(.OUT_W(OUT_W)) b_if ();

  conv_channel_accum #(.NUM_CH(4), .SHIFT(8), .OUT_W(OUT_W)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  conv_channel_accum #(.NUM_CH(1), .SHIFT(0), .OUT_W(OUT_W)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  typedef struct {
    logic [15:0] d;
    logic        s;
    int          t;
  } out_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   done;
  out_t got_a[$];
  out_t got_b[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every output handshake (sampled mid-cycle, completes at next edge).
  always @(negedge clk) begin
    if (a_if.out_valid === 1'b1 && a_if.out_ready === 1'b1)
      got_a.push_back(out_t'{a_if.out_data, a_if.out_sat, cyc});
    if (b_if.out_valid === 1'b1 && b_if.out_ready === 1'b1)
      got_b.push_back(out_t'{b_if.out_data, b_if.out_sat, cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // Reference: optional ReLU, floor shift, clamp to the output range.
  function automatic void post_ref(input longint fin, input int shift,
                                   output logic [15:0] d, output logic s);
    longint x, y, mx, mn;
    x  = fin;
    mx = (longint'(1) <<< (OUT_W - 1)) - 1;
`ifdef CONV_ACCUM_RELU_EN
    if (x < 0) x = 0;
    mn = 0;
`else
    mn = -(longint'(1) <<< (OUT_W - 1));
`endif
    y = x >>> shift;
    s = 1'b0;
    if (y > mx) begin
      y = mx; s = 1'b1;
    end else if (y < mn) begin
      y = mn; s = 1'b1;
    end
    d = 16'(y);
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? b_if.in_ready : a_if.in_ready;
  endfunction

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input bit sel, input int d, input shortint b);
    int n = 0;
    if (sel) begin
      b_if.in_valid = 1'b1; b_if.in_data = d; b_if.bias = b;
    end else begin
      a_if.in_valid = 1'b1; a_if.in_data = d; a_if.bias = b;
    end
    while (rdy(sel) !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL send_beat_timeout sel=%0d in_ready stuck low", sel);
    end
    @(posedge clk); #1;
    if (sel) b_if.in_valid = 1'b0;
    else     a_if.in_valid = 1'b0;
  endtask

  task automatic wait_got(input bit sel, input int n, input int budget);
    int k = 0;
    while ((sel ? got_b.size() : got_a.size()) < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= budget) begin
      checks++; errors++;
      $display("FAIL wait_outputs sel=%0d got %0d need %0d", sel,
               sel ? got_b.size() : got_a.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.bias = '0; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.bias = '0; b_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (a_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", a_if.in_ready); end
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a_if.out_valid); end
    checks++; if (a_if.out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data got %h exp 0", a_if.out_data); end
    checks++; if (a_if.out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got %b exp 0", a_if.out_sat); end
    checks++; if (b_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready got %b exp 1", b_if.in_ready); end
    checks++; if (b_if.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid got %b exp 0", b_if.out_valid); end
  endtask

  task automatic test_basic();
    logic [15:0] ed; logic es;
    got_a.delete();
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) send_beat(1'b0, 100 * i, 16'sd1000);
    post_ref(64'sd2000, 8, ed, es);
    @(negedge clk);
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", a_if.out_valid); end
    checks++; if (a_if.in_ready !== 1'b0) begin errors++; $display("FAIL basic_fin_in_ready got %b exp 0", a_if.in_ready); end
    @(negedge clk);
    checks++; if (a_if.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", a_if.out_valid); end
    checks++; if (a_if.out_data !== ed || a_if.out_sat !== es) begin errors++; $display("FAIL basic_data got %0d/%b exp %0d/%b", $signed(a_if.out_data), a_if.out_sat, $signed(ed), es); end
    @(negedge clk);
    checks++; if (a_if.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_width got %b exp 0", a_if.out_valid); end
    checks++; if (got_a.size() != 1) begin errors++; $display("FAIL basic_count got %0d exp 1", got_a.size()); end
  endtask

  // Four identical beats, bias 0, one pixel out; compared against the model.
  task automatic run_flat(input string name, input int d);
    logic [15:0] ed; logic es;
    got_a.delete();
    for (int i = 0; i < 4; i++) send_beat(1'b0, d, 16'sd0);
    post_ref(4 * longint'(d), 8, ed, es);
    wait_got(1'b0, 1, 50);
    if (got_a.size() >= 1) begin
      checks++;
      if (got_a[0].d !== ed || got_a[0].s !== es) begin
        errors++;
        $display("FAIL %s got %0d/%b exp %0d/%b", name, $signed(got_a[0].d), got_a[0].s, $signed(ed), es);
      end
    end
  endtask

  task automatic test_overflow();
    run_flat("pos_overflow", 32'h7FFF_FFFF);
  endtask

  task automatic test_negative();
    run_flat("neg_sum", -1000);
    run_flat("neg_overflow", 32'h8000_0000);
  endtask

  task automatic test_backpressure();
    logic [15:0] e1, e2; logic s1, s2;
    post_ref(64'sd4000, 8, e1, s1);
    post_ref(64'sd10240, 8, e2, s2);
    got_a.delete();
    a_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(1'b0, 1000, 16'sd0);
    for (int i = 0; i < 4; i++) send_beat(1'b0, 2560, 16'sd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (a_if.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got %b exp 0", k, a_if.in_ready); end
      checks++; if (a_if.out_valid !== 1'b1 || a_if.out_data !== e1) begin errors++; $display("FAIL bp_hold c%0d got %b/%0d exp 1/%0d", k, a_if.out_valid, $signed(a_if.out_data), $signed(e1)); end
    end
    @(posedge clk); #1 a_if.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (a_if.out_valid !== 1'b1 || a_if.out_data !== e2) begin errors++; $display("FAIL bp_handoff got %b/%0d exp 1/%0d", a_if.out_valid, $signed(a_if.out_data), $signed(e2)); end
    wait_got(1'b0, 2, 20);
    if (got_a.size() >= 2) begin
      checks++; if (got_a[0].d !== e1 || got_a[1].d !== e2) begin errors++; $display("FAIL bp_order got %0d,%0d exp %0d,%0d", $signed(got_a[0].d), $signed(got_a[1].d), $signed(e1), $signed(e2)); end
      checks++; if (got_a[1].t - got_a[0].t != 1) begin errors++; $display("FAIL bp_spacing got %0d exp 1", got_a[1].t - got_a[0].t); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ed; logic es;
    @(posedge clk); #1;
    got_a.delete();
    send_beat(1'b0, 5000, 16'sd0);
    send_beat(1'b0, 5000, 16'sd0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(1'b0, 256, 16'sd0);
    repeat (10) @(posedge clk);
    #1;
    post_ref(64'sd1024, 8, ed, es);
    checks++; if (got_a.size() != 1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", got_a.size()); end
    if (got_a.size() >= 1) begin
      checks++; if (got_a[0].d !== ed || got_a[0].s !== es) begin errors++; $display("FAIL rstmid_data got %0d/%b exp %0d/%b", $signed(got_a[0].d), got_a[0].s, $signed(ed), es); end
    end
  endtask

  task automatic test_bias_ch1();
    logic [15:0] ed; logic es;
    got_b.delete();
    @(posedge clk); #1;
    for (int i = 1; i <= 3; i++) begin
      send_beat(1'b1, 10 * i, shortint'(i));
      checks++; if (b_if.in_ready !== 1'b0) begin errors++; $display("FAIL ch1_in_ready_low beat%0d got %b exp 0", i, b_if.in_ready); end
    end
    wait_got(1'b1, 3, 20);
    for (int i = 0; i < got_b.size() && i < 3; i++) begin
      post_ref(longint'(11 * (i + 1)), 0, ed, es);
      checks++; if (got_b[i].d !== ed || got_b[i].s !== es) begin errors++; $display("FAIL ch1_data%0d got %0d/%b exp %0d/%b", i, $signed(got_b[i].d), got_b[i].s, $signed(ed), es); end
      if (i > 0) begin
        checks++; if (got_b[i].t - got_b[i-1].t != 2) begin errors++; $display("FAIL ch1_spacing%0d got %0d exp 2", i, got_b[i].t - got_b[i-1].t); end
      end
    end
  endtask

  task automatic test_random();
    localparam int NPIX = 40;
    logic [15:0] exp_d[$];
    logic        exp_s[$];
    got_a.delete();
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < NPIX; p++) begin
          longint  sum;
          shortint b0;
          b0  = shortint'($urandom);
          sum = longint'(b0);
          for (int c = 0; c < 4; c++) begin
            int d;
            if ($urandom_range(0, 3) == 0) d = int'($urandom);
            else d = int'($urandom_range(0, 200000)) - 100000;
            if ($urandom_range(0, 3) == 0)
              repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            send_beat(1'b0, d, (c == 0) ? b0 : shortint'($urandom));
            sum += longint'(d);
          end
          begin
            logic [15:0] ed; logic es;
            post_ref(sum, 8, ed, es);
            exp_d.push_back(ed);
            exp_s.push_back(es);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          a_if.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    a_if.out_ready = 1'b1;
    wait_got(1'b0, NPIX, 100);
    checks++; if (got_a.size() != NPIX) begin errors++; $display("FAIL rand_count got %0d exp %0d", got_a.size(), NPIX); end
    for (int i = 0; i < NPIX && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i].d !== exp_d[i] || got_a[i].s !== exp_s[i]) begin
        errors++;
        $display("FAIL rand_pix%0d got %0d/%b exp %0d/%b", i, $signed(got_a[i].d), got_a[i].s, $signed(exp_d[i]), exp_s[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_negative();
    test_backpressure();
    test_reset_mid();
    test_bias_ch1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
